lsu_mem_ctrl: RTL

// Load/store unit: requester side of the data-memory port (word address, byte enables,

---
 rtl/lsu_mem_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a word-organised data memory: one request per handshake,
// misaligned accesses split into two word accesses, load bytes merged and extended.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_BITS-1:0] address_dm,
  output logic [31:0]          writedata_dm,
  output logic [3:0]           byte_en,
  output logic                 memread_dm,
  output logic                 memwrite_dm,
  input  logic [31:0]          mem_data
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q, err_q;
  logic [2:0]            f3_q;
  logic [ADDR_BITS+1:0]  addr_q;
  logic [31:0]           wdata_q, word0_q, word1_q;

  logic                  legal;
  logic [1:0]            off;
  logic [2:0]            nbytes, sh1;
  logic [3:0]            mask;
  logic                  split;
  logic [ADDR_BITS-1:0]  w0, w1;
  logic [31:0]           merged, ext;

  always_comb begin
    legal = 1'b0;
    if (req_we) legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  // Geometry of the captured request
  always_comb begin
    off = addr_q[1:0];
    w0  = addr_q[ADDR_BITS+1:2];
    w1  = w0 + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    unique case (f3_q[1:0])
      2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
      default: begin nbytes = 3'd4; mask = 4'b1111; end
    endcase
    split  = ({1'b0, off} + nbytes) > 3'd4;
    sh1    = 3'd4 - {1'b0, off};
    merged = 32'({word1_q, word0_q} >> {off, 3'b000});
    unique case (f3_q)
      3'b000:  ext = {{24{merged[7]}}, merged[7:0]};
      3'b001:  ext = {{16{merged[15]}}, merged[15:0]};
      3'b100:  ext = {24'h0, merged[7:0]};
      3'b101:  ext = {16'h0, merged[15:0]};
      default: ext = merged;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = 32'h0;
    address_dm   = '0;
    writedata_dm = 32'h0;
    byte_en      = 4'b0000;
    memread_dm   = 1'b0;
    memwrite_dm  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = legal ? StAcc0 : StResp;
      end
      StAcc0: begin
        address_dm   = w0;
        writedata_dm = wdata_q << {off, 3'b000};
        byte_en      = we_q ? (mask << off) : 4'b0000;
        memread_dm   = !we_q;
        memwrite_dm  = we_q;
        state_d      = split ? StAcc1 : StResp;
      end
      StAcc1: begin
        address_dm   = w1;
        writedata_dm = wdata_q >> {sh1, 3'b000};
        byte_en      = we_q ? (mask >> sh1) : 4'b0000;
        memread_dm   = !we_q;
        memwrite_dm  = we_q;
        state_d      = StResp;
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'h0 : ext;
        if (resp_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      word0_q <= 32'h0;
      word1_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        we_q    <= req_we;
        err_q   <= !legal;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[ADDR_BITS+1:0];
        wdata_q <= req_wdata;
        word0_q <= 32'h0;
        word1_q <= 32'h0;
      end
      if (state_q == StAcc0 && !we_q) word0_q <= mem_data;
      if (state_q == StAcc1 && !we_q) word1_q <= mem_data;
    end
  end

endmodule
